// File: rtl/mdu_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
package mdu_pkg;

  localparam int MDU_DATA_W = 32;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL     = 2'd1,
    DIV_RUN = 2'd2,
    DONE    = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/mdu_div_core.sv
// Iterative unsigned restoring divider: one quotient bit per step_en cycle.
module mdu_div_core
  import mdu_pkg::*;
#(
  parameter int DATA_W = MDU_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              step_en,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] dsr_q;
  logic [DATA_W:0]   rem_shift;
  logic [DATA_W:0]   diff;

  // Partial remainder shifted left by one, pulling in the next dividend bit.
  // Bit DATA_W of the difference is the borrow: set means "restore".
  assign rem_shift = {rem_q, quo_q[DATA_W-1]};
  assign diff      = rem_shift - {1'b0, dsr_q};

  // Load operands, then shift dividend bits out / quotient bits in per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dsr_q <= divisor;
    end else if (step_en) begin
      if (!diff[DATA_W]) begin
        rem_q <= diff[DATA_W-1:0];
        quo_q <= {quo_q[DATA_W-2:0], 1'b1};
      end else begin
        rem_q <= rem_shift[DATA_W-1:0];
        quo_q <= {quo_q[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/hilo_mdu_ctrl.sv
// HI/LO multiply/divide sequencer for the EX stage. Stalls IF..EX while a
// multi-cycle op runs and issues exactly one HI/LO write per accepted op.
//
// Handshake: EX raises start with op/src_a/src_b and keeps them stable for as
// long as stall_req=1. A mul/div is accepted in the IDLE cycle where
// start=1 and flush=0; the write appears in the DONE cycle, the first cycle
// with stall_req=0, and EX still shows the same op there (it is not
// re-accepted because start only matters in IDLE). MTHI/MTLO complete
// combinationally in the IDLE cycle they are presented.
module hilo_mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int DATA_W = MDU_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic [DATA_W-1:0] hi_in,
  input  logic [DATA_W-1:0] lo_in,
  input  logic              flush,
  output logic              stall_req,
  output logic              hilo_we,
  output logic [DATA_W-1:0] hi_wdata,
  output logic [DATA_W-1:0] lo_wdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);

  mdu_state_t          state, state_next;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] prod_q;
  logic [DATA_W-1:0]   dividend_q;
  logic                res_mul_q;
  logic                div_zero_q;
  logic                q_neg_q;
  logic                r_neg_q;

  logic                op_mul, op_div, op_signed;
  logic                accept_mul, accept_div;
  logic [DATA_W-1:0]   abs_a, abs_b;
  logic [2*DATA_W-1:0] prod_next;
  logic [DATA_W-1:0]   quo_raw, rem_raw;
  logic [DATA_W-1:0]   quo_fix, rem_fix;

  assign op_mul     = (op == MDU_MULT) || (op == MDU_MULTU);
  assign op_div     = (op == MDU_DIV)  || (op == MDU_DIVU);
  assign op_signed  = (op == MDU_MULT) || (op == MDU_DIV);
  assign accept_mul = (state == IDLE) && start && op_mul && !flush;
  assign accept_div = (state == IDLE) && start && op_div && !flush;

  // Magnitudes fed to the unsigned divider; DIVU passes raw values.
  assign abs_a = (op_signed && src_a[DATA_W-1]) ? -src_a : src_a;
  assign abs_b = (op_signed && src_b[DATA_W-1]) ? -src_b : src_b;

  // Full-width product; sign-extending to 2*DATA_W gives the signed form.
  assign prod_next = op_signed
    ? ({{DATA_W{src_a[DATA_W-1]}}, src_a} * {{DATA_W{src_b[DATA_W-1]}}, src_b})
    : ({{DATA_W{1'b0}}, src_a} * {{DATA_W{1'b0}}, src_b});

  mdu_div_core #(.DATA_W(DATA_W)) u_div_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept_div),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .step_en   (state == DIV_RUN),
    .quotient  (quo_raw),
    .remainder (rem_raw)
  );

  // Sign fixup. The most-negative / -1 case needs no special path: the
  // magnitude quotient is 2^(DATA_W-1), which negates to itself, remainder 0.
  assign quo_fix = q_neg_q ? -quo_raw : quo_raw;
  assign rem_fix = r_neg_q ? -rem_raw : rem_raw;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Operand/result capture on accept and the divide iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      prod_q     <= '0;
      dividend_q <= '0;
      res_mul_q  <= 1'b0;
      div_zero_q <= 1'b0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
    end else begin
      if (accept_mul) begin
        prod_q    <= prod_next;
        res_mul_q <= 1'b1;
      end
      if (accept_div) begin
        dividend_q <= src_a;
        res_mul_q  <= 1'b0;
        div_zero_q <= (src_b == '0);
        q_neg_q    <= op_signed && (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
        r_neg_q    <= op_signed && src_a[DATA_W-1];
        cnt        <= '0;
      end else if (state == DIV_RUN) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Next-state logic. The product is registered on the accept edge, so a
  // multiply goes straight to DONE; MUL is decoded as a one-cycle stall
  // state that also leads to DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept_mul)      state_next = DONE;
        else if (accept_div) state_next = DIV_RUN;
      end
      MUL:     state_next = DONE;
      DIV_RUN: if (cnt == CNT_W'(DATA_W - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // Stall and HI/LO write outputs; forced to 0 while reset is asserted so
  // the async reset clears them even when EX keeps start high.
  always_comb begin
    stall_req = 1'b0;
    hilo_we   = 1'b0;
    hi_wdata  = '0;
    lo_wdata  = '0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (start && !flush) begin
            if (op_mul || op_div) begin
              stall_req = 1'b1;
            end else if (op == MDU_MTHI) begin
              hilo_we  = 1'b1;
              hi_wdata = src_a;
              lo_wdata = lo_in;
            end else if (op == MDU_MTLO) begin
              hilo_we  = 1'b1;
              hi_wdata = hi_in;
              lo_wdata = src_a;
            end
          end
        end
        MUL, DIV_RUN: stall_req = 1'b1;
        DONE: begin
          if (!flush) begin
            hilo_we = 1'b1;
            if (res_mul_q) begin
              hi_wdata = prod_q[2*DATA_W-1:DATA_W];
              lo_wdata = prod_q[DATA_W-1:0];
            end else if (div_zero_q) begin
              hi_wdata = dividend_q;
              lo_wdata = '1;
            end else begin
              hi_wdata = rem_fix;
              lo_wdata = quo_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Self-checking bench for hilo_mdu_ctrl: directed cases plus randomized ops
// against a behavioural HI/LO model.
module tb_hilo_mdu_ctrl;
  import mdu_pkg::*;

  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] src_a, src_b, hi_in, lo_in;
  logic              flush;
  logic              stall_req, hilo_we, busy;
  logic [DATA_W-1:0] hi_wdata, lo_wdata;

  int checks = 0;
  int errors = 0;
  logic [2*DATA_W-1:0] exp_q[$];

  hilo_mdu_ctrl #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .hi_in     (hi_in),
    .lo_in     (lo_in),
    .flush     (flush),
    .stall_req (stall_req),
    .hilo_we   (hilo_we),
    .hi_wdata  (hi_wdata),
    .lo_wdata  (lo_wdata),
    .busy      (busy)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural result {hi, lo} from the architectural rules.
  function automatic logic [2*DATA_W-1:0] ref_model(input logic [2:0] o,
      input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
      input logic [DATA_W-1:0] hin, input logic [DATA_W-1:0] lin);
    longint sa, sb;
    int     ia, ib, q, r;
    case (o)
      MDU_MULT: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
      end
      MDU_MULTU: return {32'd0, a} * {32'd0, b};
      MDU_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        ia = $signed(a);
        ib = $signed(b);
        q  = ia / ib;
        r  = ia % ib;
        return {32'(r), 32'(q)};
      end
      MDU_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      MDU_MTHI: return {a, lin};
      default:  return {hin, a};
    endcase
  endfunction

  // Drive one op, wait for its write, check data, stall length and that
  // holding start through DONE does not relaunch it.
  task automatic run_mdu(input logic [2:0] o, input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] hin,
      input logic [DATA_W-1:0] lin, input logic [2*DATA_W-1:0] exp_v,
      input string name);
    logic [2*DATA_W-1:0] exp;
    int stalls, exp_stall;
    bit got;
    exp_q.push_back(exp_v);
    if (o == MDU_MULT || o == MDU_MULTU)     exp_stall = 1;
    else if (o == MDU_DIV || o == MDU_DIVU)  exp_stall = DATA_W + 1;
    else                                     exp_stall = 0;
    start = 1'b1; op = o; src_a = a; src_b = b; hi_in = hin; lo_in = lin;
    stalls = 0;
    got = 1'b0;
    for (int c = 0; c < DATA_W + 10 && !got; c++) begin
      @(negedge clk);
      if (hilo_we) begin
        got = 1'b1;
        exp = exp_q.pop_front();
        checks++;
        if ({hi_wdata, lo_wdata} !== exp) begin
          errors++;
          $display("FAIL %s data: got hi=%h lo=%h want hi=%h lo=%h", name,
                   hi_wdata, lo_wdata, exp[63:32], exp[31:0]);
        end
        checks++;
        if (stall_req !== 1'b0) begin
          errors++;
          $display("FAIL %s stall_with_we: got %b want 0", name, stall_req);
        end
      end else if (stall_req) begin
        stalls++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!got) begin
      errors++;
      void'(exp_q.pop_front());
      $display("FAIL %s timeout: hilo_we never seen within %0d cycles", name, DATA_W + 10);
    end
    checks++;
    if (stalls != exp_stall) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d want %0d", name, stalls, exp_stall);
    end
    start = 1'b0;
    src_a = $urandom;
    src_b = $urandom;
    @(negedge clk);
    checks++;
    if (hilo_we !== 1'b0 || stall_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: got we=%b stall=%b busy=%b want 0 0 0", name,
               hilo_we, stall_req, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = MDU_MULT; flush = 1'b0;
    src_a = '0; src_b = '0; hi_in = '0; lo_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({stall_req, hilo_we, busy} !== 3'b000 || hi_wdata !== '0 || lo_wdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got stall=%b we=%b busy=%b hi=%h lo=%h want all 0",
               stall_req, hilo_we, busy, hi_wdata, lo_wdata);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hilo_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got busy=%b we=%b want 0 0", busy, hilo_we);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_mdu(MDU_MULT, 32'hFFFF_FFFE, 32'd3, '0, '0, {32'hFFFF_FFFF, 32'hFFFF_FFFA}, "mult_neg2x3");
    run_mdu(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, '0, {32'hFFFF_FFFE, 32'h0000_0001}, "multu_max");
    run_mdu(MDU_DIVU, 32'd100, 32'd7, '0, '0, {32'd2, 32'd14}, "divu_100_7");
    run_mdu(MDU_DIV, 32'hFFFF_FFF9, 32'd2, '0, '0, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_m7_2");
    run_mdu(MDU_DIV, 32'd5, 32'd0, '0, '0, {32'd5, 32'hFFFF_FFFF}, "div_by_zero");
    run_mdu(MDU_DIVU, 32'hFFFF_FFF9, 32'd0, '0, '0, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, "divu_by_zero");
    run_mdu(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, '0, '0, {32'd0, 32'h8000_0000}, "div_overflow");
    run_mdu(MDU_DIV, 32'd7, 32'hFFFF_FFFE, '0, '0, {32'd1, 32'hFFFF_FFFD}, "div_7_m2");
  endtask

  task automatic test_mt();
    run_mdu(MDU_MTHI, 32'h1234, $urandom, 32'h5555, 32'hABCD, {32'h1234, 32'hABCD}, "mthi");
    run_mdu(MDU_MTLO, 32'h9876, $urandom, 32'h4321, 32'h7777, {32'h4321, 32'h9876}, "mtlo");
  endtask

  task automatic test_flush_div();
    int we_seen;
    start = 1'b1; op = MDU_DIVU; src_a = 32'd1000; src_b = 32'd3;
    repeat (11) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (hilo_we !== 1'b0) begin
      errors++;
      $display("FAIL flush_div_we: got %b want 0", hilo_we);
    end
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (stall_req !== 1'b0 || busy !== 1'b0 || hilo_we !== 1'b0) begin
      errors++;
      $display("FAIL flush_div_idle: got stall=%b busy=%b we=%b want 0 0 0",
               stall_req, busy, hilo_we);
    end
    we_seen = 0;
    repeat (DATA_W + 4) begin
      @(negedge clk);
      if (hilo_we) we_seen++;
    end
    checks++;
    if (we_seen != 0) begin
      errors++;
      $display("FAIL flush_div_no_write: got %0d writes want 0", we_seen);
    end
    @(posedge clk); #1;
    run_mdu(MDU_MULT, 32'd2, 32'd3, '0, '0, {32'd0, 32'd6}, "mult_after_flush");
  endtask

  task automatic test_flush_done();
    start = 1'b1; op = MDU_MULT; src_a = 32'd5; src_b = 32'd7;
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (hilo_we !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_done: got we=%b busy=%b want 0 1", hilo_we, busy);
    end
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hilo_we !== 1'b0) begin
      errors++;
      $display("FAIL flush_done_idle: got busy=%b we=%b want 0 0", busy, hilo_we);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    start = 1'b1; op = MDU_DIVU; src_a = 32'd1000; src_b = 32'd7;
    repeat (6) begin
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({stall_req, hilo_we, busy} !== 3'b000 || hi_wdata !== '0 || lo_wdata !== '0) begin
      errors++;
      $display("FAIL reset_mid: got stall=%b we=%b busy=%b hi=%h lo=%h want all 0",
               stall_req, hilo_we, busy, hi_wdata, lo_wdata);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_mdu(MDU_DIVU, 32'd9, 32'd3, '0, '0, {32'd0, 32'd3}, "divu_after_reset");
  endtask

  task automatic test_random_back_to_back();
    logic [2:0]        o;
    logic [DATA_W-1:0] a, b, hin, lin;
    for (int i = 0; i < 24; i++) begin
      o   = 3'($urandom_range(0, 5));
      a   = $urandom;
      hin = $urandom;
      lin = $urandom;
      case ($urandom_range(0, 4))
        0:       b = '0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      run_mdu(o, a, b, hin, lin, ref_model(o, a, b, hin, lin), "random");
    end
  endtask

  // Test sequence and report.
  initial begin
    test_reset();
    test_directed();
    test_mt();
    test_flush_div();
    test_flush_done();
    test_reset_mid();
    test_random_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
